color_vote_sequencer: RTL

//  Downstream controller/consumer for the colour-classification stage. Repeatedly

---
 rtl/color_vote_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/color_vote_sequencer.sv
// Colour vote sequencer: drives the classifier through repeated samples
// and majority-votes each window of verdicts into one colour code.
module color_vote_sequencer #(
  parameter int VOTES          = 3,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       sens_red,
  input  logic       sens_green,
  input  logic       sens_blue,
  input  logic       sens_done,
  output logic       sens_rst,
  output logic       sens_go,
  output logic [1:0] color,
  output logic       color_valid,
  output logic [7:0] timeout_cnt,
  output logic       busy
);

  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [3:0]    VOTES_N   = 4'(VOTES);
  localparam logic [3:0]    HALF      = 4'(VOTES / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_GO,
    S_WAIT,
    S_REC,
    S_VOID,
    S_GAP,
    S_DECIDE
  } stateT;

  stateT         state, stateNext;
  logic [WW-1:0] waitCnt, waitNext;
  logic [GW-1:0] gapCnt, gapNext;
  logic [3:0]    sampleIdx, idxNext;
  logic [3:0]    redVotes, redNext;
  logic [3:0]    greenVotes, greenNext;
  logic [3:0]    blueVotes, blueNext;
  logic [1:0]    colorReg, colorNext;
  logic [7:0]    timeoutCnt, toNext;
  logic [7:0]    toInc;
  logic [1:0]    decided;
  logic          lastSample;

  assign toInc = (timeoutCnt == 8'hFF) ? timeoutCnt
                                       : timeoutCnt + 8'd1;
  assign lastSample = (sampleIdx == VOTES_N - 4'd1);

  always_comb begin
    decided = 2'b00;
    unique case (1'b1)
      (redVotes > HALF):   decided = 2'b01;
      (greenVotes > HALF): decided = 2'b10;
      (blueVotes > HALF):  decided = 2'b11;
      default:             decided = 2'b00;
    endcase
  end

  always_comb begin
    stateNext   = state;
    waitNext    = waitCnt;
    gapNext     = gapCnt;
    idxNext     = sampleIdx;
    redNext     = redVotes;
    greenNext   = greenVotes;
    blueNext    = blueVotes;
    colorNext   = colorReg;
    toNext      = timeoutCnt;
    sens_rst    = 1'b0;
    sens_go     = 1'b0;
    color_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) stateNext = S_RST;
      end
      S_RST: begin
        sens_rst  = 1'b1;
        stateNext = S_GO;
      end
      S_GO: begin
        sens_go   = 1'b1;
        waitNext  = '0;
        stateNext = S_WAIT;
      end
      S_WAIT: begin
        // done beats a timeout landing on the same cycle
        if (sens_done) stateNext = S_REC;
        else if (waitCnt == WAIT_LAST) stateNext = S_VOID;
        else waitNext = waitCnt + 1'b1;
      end
      S_REC: begin
        idxNext = sampleIdx + 4'd1;
        gapNext = '0;
        unique case ({sens_red, sens_green, sens_blue})
          3'b100:  redNext   = redVotes + 4'd1;
          3'b010:  greenNext = greenVotes + 4'd1;
          3'b001:  blueNext  = blueVotes + 4'd1;
          default: toNext    = toInc;
        endcase
        stateNext = lastSample ? S_DECIDE : S_GAP;
      end
      S_VOID: begin
        idxNext   = sampleIdx + 4'd1;
        gapNext   = '0;
        toNext    = toInc;
        stateNext = lastSample ? S_DECIDE : S_GAP;
      end
      S_GAP: begin
        if (gapCnt == GAP_LAST) stateNext = S_RST;
        else gapNext = gapCnt + 1'b1;
      end
      S_DECIDE: begin
        color_valid = 1'b1;
        colorNext   = decided;
        idxNext     = '0;
        redNext     = '0;
        greenNext   = '0;
        blueNext    = '0;
        gapNext     = '0;
        stateNext   = enable ? S_GAP : S_IDLE;
      end
    endcase
  end

  assign color       = colorNext;
  assign timeout_cnt = timeoutCnt;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      waitCnt    <= '0;
      gapCnt     <= '0;
      sampleIdx  <= '0;
      redVotes   <= '0;
      greenVotes <= '0;
      blueVotes  <= '0;
      colorReg   <= '0;
      timeoutCnt <= '0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitNext;
      gapCnt     <= gapNext;
      sampleIdx  <= idxNext;
      redVotes   <= redNext;
      greenVotes <= greenNext;
      blueVotes  <= blueNext;
      colorReg   <= colorNext;
      timeoutCnt <= toNext;
    end
  end

endmodule
